// File: rtl/aes_axi_fifo_if.sv
// rtl/aes_axi_fifo_if.sv - AXI4 slave front-end for the AES-256 core
// Seed, data-in and data-out FIFOs, status/control registers and engine handshakes.

module aes_axi_fifo_if #(
  parameter int OUT_DEPTH = 8
) (
  input  logic          s00_axi_aclk,
  input  logic          s00_axi_aresetn,
  input  logic [5:0]    s00_axi_awaddr,
  input  logic [7:0]    s00_axi_awlen,
  input  logic [2:0]    s00_axi_awsize,
  input  logic [1:0]    s00_axi_awburst,
  input  logic          s00_axi_awid,
  input  logic          s00_axi_awvalid,
  output logic          s00_axi_awready,
  input  logic [31:0]   s00_axi_wdata,
  input  logic [3:0]    s00_axi_wstrb,
  input  logic          s00_axi_wlast,
  input  logic          s00_axi_wvalid,
  output logic          s00_axi_wready,
  output logic [1:0]    s00_axi_bresp,
  output logic          s00_axi_bid,
  output logic          s00_axi_bvalid,
  input  logic          s00_axi_bready,
  input  logic [5:0]    s00_axi_araddr,
  input  logic [7:0]    s00_axi_arlen,
  input  logic [2:0]    s00_axi_arsize,
  input  logic [1:0]    s00_axi_arburst,
  input  logic          s00_axi_arvalid,
  output logic          s00_axi_arready,
  output logic [31:0]   s00_axi_rdata,
  output logic [1:0]    s00_axi_rresp,
  output logic          s00_axi_rlast,
  output logic          s00_axi_rvalid,
  input  logic          s00_axi_rready,
  output logic [31:0]   s01_reg_status,
  output logic [31:0]   s02_reg_control,
  output logic [255:0]  aes_key,
  output logic          aes_kg_start,
  input  logic          aes_kg_done,
  output logic [127:0]  aes_din,
  output logic          aes_enc_start,
  output logic          aes_dec_start,
  input  logic          aes_done,
  input  logic [127:0]  aes_dout
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] OUT_FULL = CW'(OUT_DEPTH);
  localparam logic [CW-1:0] OUT_ROOM = CW'(OUT_DEPTH - 4);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  wr_state_e       wr_state_q, wr_state_d;
  rd_state_e       rd_state_q, rd_state_d;
  logic [5:0]      awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [7:0]      awlen_q, awlen_d, wbeat_q, wbeat_d, arlen_q, arlen_d, rbeat_q, rbeat_d;
  logic            awid_q, awid_d, berr_q, berr_d;
  logic            rvalid_q, rvalid_d, rlast_q, rlast_d, rpop_q, rpop_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [31:0]     seed_q [8];
  logic [31:0]     seed_d [8];
  logic [2:0]      seed_cnt_q, seed_cnt_d;
  logic            kg_start_q, kg_start_d, kg_fin_q, kg_fin_d;
  logic [31:0]     din_q [4];
  logic [31:0]     din_d [4];
  logic [2:0]      din_cnt_q, din_cnt_d;
  logic [127:0]    aes_din_q, aes_din_d;
  logic            enc_start_q, enc_start_d, dec_start_q, dec_start_d;
  logic [1:0]      busy_q, busy_d;
  logic [31:0]     ctrl_q, ctrl_d, status_q, status_d;
  logic [31:0]     dout_q [OUT_DEPTH];
  logic [31:0]     dout_d [OUT_DEPTH];
  logic [AW-1:0]   dout_wp_q, dout_wp_d, dout_rp_q, dout_rp_d;
  logic [CW-1:0]   dout_cnt_q, dout_cnt_d;
  logic            pop, push4, ctrl_ok;
  logic            unused_ok;

  assign unused_ok = ^{s00_axi_awsize, s00_axi_awburst, s00_axi_wstrb,
                       s00_axi_arsize, s00_axi_arburst};

  // The result push needs four free slots, so they are reserved before starting.
  assign ctrl_ok = kg_fin_q && (din_cnt_q == 3'd4) && (busy_q == 2'b00) &&
                   (dout_cnt_q <= OUT_ROOM);

  always_comb begin
    wr_state_d  = wr_state_q;   rd_state_d = rd_state_q;
    awaddr_d    = awaddr_q;     awlen_d    = awlen_q;    awid_d  = awid_q;
    wbeat_d     = wbeat_q;      berr_d     = berr_q;
    araddr_d    = araddr_q;     arlen_d    = arlen_q;    rbeat_d = rbeat_q;
    rvalid_d    = rvalid_q;     rlast_d    = rlast_q;    rpop_d  = rpop_q;
    rdata_d     = rdata_q;      rresp_d    = rresp_q;
    seed_d      = seed_q;       seed_cnt_d = seed_cnt_q;
    kg_start_d  = 1'b0;         kg_fin_d   = kg_fin_q;
    din_d       = din_q;        din_cnt_d  = din_cnt_q;  aes_din_d = aes_din_q;
    enc_start_d = 1'b0;         dec_start_d = 1'b0;
    busy_d      = busy_q;       ctrl_d     = ctrl_q;
    dout_d      = dout_q;       dout_wp_d  = dout_wp_q;  dout_rp_d = dout_rp_q;
    s00_axi_awready = 1'b0;     s00_axi_wready = 1'b0;   s00_axi_arready = 1'b0;
    pop         = 1'b0;
    push4       = aes_done && (busy_q != 2'b00);

    unique case (wr_state_q)
      W_IDLE: begin
        s00_axi_awready = s00_axi_awvalid;
        if (s00_axi_awvalid) begin
          awaddr_d   = s00_axi_awaddr;
          awlen_d    = s00_axi_awlen;
          awid_d     = s00_axi_awid;
          wbeat_d    = 8'd0;
          berr_d     = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid) begin
          case (awaddr_q)
            6'h04: begin
              if (din_cnt_q != 3'd4) begin
                din_d[din_cnt_q[1:0]] = s00_axi_wdata;
                din_cnt_d = din_cnt_q + 3'd1;
              end else begin
                berr_d = 1'b1;
              end
            end
            6'h08: begin
              seed_d[seed_cnt_q] = s00_axi_wdata;
              seed_cnt_d = seed_cnt_q + 3'd1;
              kg_start_d = (seed_cnt_q == 3'd7);
            end
            6'h0C: begin
              if (ctrl_ok && ((s00_axi_wdata == 32'd1) || (s00_axi_wdata == 32'd2))) begin
                aes_din_d   = {din_q[0], din_q[1], din_q[2], din_q[3]};
                enc_start_d = s00_axi_wdata[0];
                dec_start_d = s00_axi_wdata[1];
                busy_d      = s00_axi_wdata[1:0];
                ctrl_d      = s00_axi_wdata;
                din_d       = '{default: '0};
                din_cnt_d   = 3'd0;
              end else begin
                berr_d = 1'b1;
              end
            end
            default: berr_d = 1'b1;
          endcase
          if (s00_axi_wlast || (wbeat_q == awlen_q)) wr_state_d = W_RESP;
          else wbeat_d = wbeat_q + 8'd1;
        end
      end
      W_RESP: if (s00_axi_bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase

    if (kg_start_d) kg_fin_d = 1'b0;
    else if (aes_kg_done) kg_fin_d = 1'b1;

    // Each beat is latched while rvalid is low so rdata cannot move under a held beat.
    unique case (rd_state_q)
      R_IDLE: begin
        s00_axi_arready = s00_axi_arvalid;
        if (s00_axi_arvalid) begin
          araddr_d   = s00_axi_araddr;
          arlen_d    = s00_axi_arlen;
          rbeat_d    = 8'd0;
          rvalid_d   = 1'b0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rlast_d  = (rbeat_q == arlen_q);
          rpop_d   = 1'b0;
          rresp_d  = 2'b00;
          rdata_d  = 32'd0;
          case (araddr_q)
            6'h00: rdata_d = status_q;
            6'h04: begin
              if (dout_cnt_q != '0) begin
                rdata_d = dout_q[dout_rp_q];
                rpop_d  = 1'b1;
              end else begin
                rresp_d = 2'b10;
              end
            end
            6'h08: rdata_d = {29'd0, seed_cnt_q};
            6'h0C: rdata_d = ctrl_q;
            default: rresp_d = 2'b10;
          endcase
        end else if (s00_axi_rready) begin
          pop      = rpop_q;
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          rpop_d   = 1'b0;
          rdata_d  = 32'd0;
          rresp_d  = 2'b00;
          if (rlast_q) rd_state_d = R_IDLE;
          else rbeat_d = rbeat_q + 8'd1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    if (pop) dout_rp_d = dout_rp_q + AW'(1);
    if (push4) begin
      for (int k = 0; k < 4; k++) dout_d[dout_wp_q + AW'(k)] = aes_dout[127-32*k -: 32];
      dout_wp_d = dout_wp_q + AW'(4);
      busy_d    = 2'b00;
      ctrl_d    = 32'd0;
    end
    dout_cnt_d = dout_cnt_q + (push4 ? CW'(4) : CW'(0)) - (pop ? CW'(1) : CW'(0));

    status_d        = 32'd0;
    status_d[1:0]   = busy_d;
    status_d[2]     = kg_fin_d;
    status_d[3]     = (din_cnt_d == 3'd4);
    status_d[4]     = (dout_cnt_d == '0);
    status_d[5]     = (dout_cnt_d == OUT_FULL);
    status_d[10:8]  = din_cnt_d;
    status_d[14:11] = 4'(dout_cnt_d);
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_aresetn) begin
    if (s00_axi_aresetn) begin
      wr_state_q <= W_IDLE;   rd_state_q <= R_IDLE;
      awaddr_q   <= '0;       awlen_q    <= '0;  awid_q  <= 1'b0;
      wbeat_q    <= '0;       berr_q     <= 1'b0;
      araddr_q   <= '0;       arlen_q    <= '0;  rbeat_q <= '0;
      rvalid_q   <= 1'b0;     rlast_q    <= 1'b0; rpop_q <= 1'b0;
      rdata_q    <= '0;       rresp_q    <= '0;
      seed_q     <= '{default: '0};  seed_cnt_q <= '0;
      kg_start_q <= 1'b0;     kg_fin_q   <= 1'b0;
      din_q      <= '{default: '0};  din_cnt_q  <= '0;
      aes_din_q  <= '0;       enc_start_q <= 1'b0; dec_start_q <= 1'b0;
      busy_q     <= '0;       ctrl_q     <= '0;  status_q <= '0;
      dout_q     <= '{default: '0};
      dout_wp_q  <= '0;       dout_rp_q  <= '0;  dout_cnt_q <= '0;
    end else begin
      wr_state_q <= wr_state_d; rd_state_q <= rd_state_d;
      awaddr_q   <= awaddr_d;   awlen_q    <= awlen_d;  awid_q  <= awid_d;
      wbeat_q    <= wbeat_d;    berr_q     <= berr_d;
      araddr_q   <= araddr_d;   arlen_q    <= arlen_d;  rbeat_q <= rbeat_d;
      rvalid_q   <= rvalid_d;   rlast_q    <= rlast_d;  rpop_q  <= rpop_d;
      rdata_q    <= rdata_d;    rresp_q    <= rresp_d;
      seed_q     <= seed_d;     seed_cnt_q <= seed_cnt_d;
      kg_start_q <= kg_start_d; kg_fin_q   <= kg_fin_d;
      din_q      <= din_d;      din_cnt_q  <= din_cnt_d;
      aes_din_q  <= aes_din_d;  enc_start_q <= enc_start_d; dec_start_q <= dec_start_d;
      busy_q     <= busy_d;     ctrl_q     <= ctrl_d;   status_q <= status_d;
      dout_q     <= dout_d;
      dout_wp_q  <= dout_wp_d;  dout_rp_q  <= dout_rp_d; dout_cnt_q <= dout_cnt_d;
    end
  end

  assign s00_axi_bvalid  = (wr_state_q == W_RESP);
  assign s00_axi_bresp   = s00_axi_bvalid ? {berr_q, 1'b0} : 2'b00;
  assign s00_axi_bid     = awid_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rlast   = rlast_q;
  assign s01_reg_status  = status_q;
  assign s02_reg_control = ctrl_q;
  assign aes_key = {seed_q[0], seed_q[1], seed_q[2], seed_q[3],
                    seed_q[4], seed_q[5], seed_q[6], seed_q[7]};
  assign aes_kg_start  = kg_start_q;
  assign aes_din       = aes_din_q;
  assign aes_enc_start = enc_start_q;
  assign aes_dec_start = dec_start_q;

endmodule

// File: tb/tb_aes_axi_fifo_if.sv
// tb/tb_aes_axi_fifo_if.sv - directed table-driven bench for aes_axi_fifo_if
// Register/FIFO traffic from a vector table plus hand sequences for pulses, bursts and reset.

module tb_aes_axi_fifo_if;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   awaddr = '0;  logic [7:0] awlen = '0;  logic [2:0] awsize = 3'd2;
  logic [1:0]   awburst = '0; logic awid = 1'b0;       logic awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;   logic [3:0] wstrb = 4'hF; logic wlast = 1'b0;
  logic         wvalid = 1'b0; logic wready;
  logic [1:0]   bresp;        logic bid; logic bvalid; logic bready = 1'b0;
  logic [5:0]   araddr = '0;  logic [7:0] arlen = '0;  logic [2:0] arsize = 3'd2;
  logic [1:0]   arburst = '0; logic arvalid = 1'b0;    logic arready;
  logic [31:0]  rdata;        logic [1:0] rresp;       logic rlast;
  logic         rvalid;       logic rready = 1'b0;
  logic [31:0]  status, control;
  logic [255:0] aes_key;      logic aes_kg_start;      logic aes_kg_done = 1'b0;
  logic [127:0] aes_din;      logic aes_enc_start, aes_dec_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_dout = '0;

  aes_axi_fifo_if #(.OUT_DEPTH(8)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen), .s00_axi_awsize(awsize),
    .s00_axi_awburst(awburst), .s00_axi_awid(awid), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wlast(wlast), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bid(bid), .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
    .s00_axi_arsize(arsize), .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rlast(rlast), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .s01_reg_status(status), .s02_reg_control(control),
    .aes_key(aes_key), .aes_kg_start(aes_kg_start), .aes_kg_done(aes_kg_done),
    .aes_din(aes_din), .aes_enc_start(aes_enc_start), .aes_dec_start(aes_dec_start),
    .aes_done(aes_done), .aes_dout(aes_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int kg_cnt = 0, enc_cnt = 0, dec_cnt = 0;

  always @(posedge clk) begin
    if (aes_kg_start)  kg_cnt  <= kg_cnt + 1;
    if (aes_enc_start) enc_cnt <= enc_cnt + 1;
    if (aes_dec_start) dec_cnt <= dec_cnt + 1;
  end

  typedef struct {
    int          phase;
    bit          rd;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] rd_data [4];
  logic [1:0]  rd_resp [4];
  logic        rd_last [4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  function automatic void vw(input int p, input logic [5:0] a, input logic [31:0] d, input logic [1:0] r);
    vec_t v;
    v.phase = p; v.rd = 1'b0; v.addr = a; v.data = d; v.resp = r;
    vecs.push_back(v);
  endfunction

  function automatic void vr(input int p, input logic [5:0] a, input logic [31:0] d, input logic [1:0] r);
    vec_t v;
    v.phase = p; v.rd = 1'b1; v.addr = a; v.data = d; v.resp = r;
    vecs.push_back(v);
  endfunction

  task automatic axi_write(input logic [5:0] addr, input logic [7:0] len,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           output logic [1:0] resp, output logic id);
    int n;
    @(negedge clk);
    awaddr = addr; awlen = len; awid = 1'b1; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("aw");
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      wdata = (i == 0) ? d0 : ((i == 1) ? d1 : d2);
      wvalid = 1'b1; wlast = (i == int'(len));
      #1;
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("w");
      @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
    end
    @(negedge clk);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("b");
    resp = bresp; id = bid;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, input logic [7:0] len);
    int n;
    @(negedge clk);
    araddr = addr; arlen = len; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("ar");
    @(posedge clk); #1 arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("r");
      rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast;
      rready = 1'b1;
      @(posedge clk); #1 rready = 1'b0;
    end
  endtask

  task automatic run_phase(input int p);
    logic [1:0] resp;
    logic       id;
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        if (vecs[i].rd) begin
          axi_read(vecs[i].addr, 8'd0);
          chk($sformatf("p%0d_v%0d_rdata", p, i), 256'(rd_data[0]), 256'(vecs[i].data));
          chk($sformatf("p%0d_v%0d_rresp", p, i), 256'(rd_resp[0]), 256'(vecs[i].resp));
          chk($sformatf("p%0d_v%0d_rlast", p, i), 256'(rd_last[0]), 256'(1'b1));
        end else begin
          axi_write(vecs[i].addr, 8'd0, vecs[i].data, 32'd0, 32'd0, resp, id);
          chk($sformatf("p%0d_v%0d_bresp", p, i), 256'(resp), 256'(vecs[i].resp));
          chk($sformatf("p%0d_v%0d_bid", p, i), 256'(id), 256'(1'b1));
        end
      end
    end
  endtask

  task automatic pulse_done(input logic [127:0] v);
    @(negedge clk); aes_dout = v; aes_done = 1'b1;
    @(negedge clk); aes_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    logic       id;
    int         n;

    // phase 0: seed collection
    vw(0, 6'h08, 32'hAAAAAAAA, 2'b00); vw(0, 6'h08, 32'hBBBBBBBB, 2'b00);
    vw(0, 6'h08, 32'hCCCCCCCC, 2'b00); vr(0, 6'h08, 32'd3, 2'b00);
    vw(0, 6'h08, 32'hDDDDDDDD, 2'b00); vw(0, 6'h08, 32'hAAAAAAAA, 2'b00);
    vw(0, 6'h08, 32'hBBBBBBBB, 2'b00); vw(0, 6'h08, 32'hCCCCCCCC, 2'b00);
    vw(0, 6'h08, 32'hDDDDDDDD, 2'b00); vr(0, 6'h08, 32'd0, 2'b00);
    // phase 1: data-in load, rejected and accepted encrypt
    vw(1, 6'h04, 32'h00010203, 2'b00); vw(1, 6'h04, 32'h04050607, 2'b00);
    vw(1, 6'h0C, 32'd1, 2'b10);        vw(1, 6'h04, 32'h08090A0B, 2'b00);
    vw(1, 6'h04, 32'h0C0D0E0F, 2'b00); vw(1, 6'h04, 32'h11111111, 2'b10);
    vr(1, 6'h00, 32'h41C, 2'b00);      vw(1, 6'h0C, 32'd0, 2'b10);
    vw(1, 6'h0C, 32'd1, 2'b00);        vr(1, 6'h0C, 32'd1, 2'b00);
    vr(1, 6'h00, 32'h15, 2'b00);       vw(1, 6'h0C, 32'd2, 2'b10);
    // phase 2: drain result, empty pop, unmapped accesses
    vr(2, 6'h04, 32'hdeae1a89, 2'b00); vr(2, 6'h04, 32'hb07f6e26, 2'b00);
    vr(2, 6'h04, 32'h246b3283, 2'b00); vr(2, 6'h04, 32'hcef7b78c, 2'b00);
    vr(2, 6'h04, 32'd0, 2'b10);        vr(2, 6'h10, 32'd0, 2'b10);
    vw(2, 6'h14, 32'h12345678, 2'b10); vw(2, 6'h00, 32'h12345678, 2'b10);
    vr(2, 6'h00, 32'h14, 2'b00);
    // phase 3: decrypt
    vw(3, 6'h04, 32'h1, 2'b00); vw(3, 6'h04, 32'h2, 2'b00);
    vw(3, 6'h04, 32'h3, 2'b00); vw(3, 6'h04, 32'h4, 2'b00);
    vw(3, 6'h0C, 32'd2, 2'b00); vr(3, 6'h00, 32'h16, 2'b00);
    // phase 4: encrypt with exactly four free output slots
    vw(4, 6'h04, 32'h5, 2'b00); vw(4, 6'h04, 32'h6, 2'b00);
    vw(4, 6'h04, 32'h7, 2'b00); vw(4, 6'h04, 32'h8, 2'b00);
    vw(4, 6'h0C, 32'd1, 2'b00); vr(4, 6'h00, 32'h2005, 2'b00);
    // phase 5: output full blocks control until room is made
    vw(5, 6'h04, 32'h9, 2'b00); vw(5, 6'h04, 32'hA, 2'b00);
    vw(5, 6'h04, 32'hB, 2'b00); vw(5, 6'h04, 32'hC, 2'b00);
    vw(5, 6'h0C, 32'd1, 2'b10);        vr(5, 6'h00, 32'h442C, 2'b00);
    vr(5, 6'h04, 32'h11111111, 2'b00); vr(5, 6'h04, 32'h22222222, 2'b00);
    vr(5, 6'h00, 32'h340C, 2'b00);     vw(5, 6'h0C, 32'd2, 2'b10);
    vr(5, 6'h04, 32'h33333333, 2'b00); vr(5, 6'h04, 32'h44444444, 2'b00);
    vw(5, 6'h0C, 32'd1, 2'b00);        vr(5, 6'h00, 32'h2005, 2'b00);
    // phase 6: drain across pointer wrap
    vr(6, 6'h04, 32'h66666666, 2'b00); vr(6, 6'h04, 32'h77777777, 2'b00);
    vr(6, 6'h04, 32'h88888888, 2'b00); vr(6, 6'h04, 32'h99999999, 2'b00);
    vr(6, 6'h04, 32'hABCD0123, 2'b00); vr(6, 6'h04, 32'h456789AB, 2'b00);
    vr(6, 6'h04, 32'hFEDCBA98, 2'b00); vr(6, 6'h04, 32'd0, 2'b10);
    vr(6, 6'h00, 32'h14, 2'b00);

    repeat (3) @(negedge clk);
    chk("rst_status", 256'(status), 256'(32'd0));
    chk("rst_control", 256'(control), 256'(32'd0));
    chk("rst_key", aes_key, 256'd0);
    chk("rst_bvalid_rvalid", 256'({bvalid, rvalid, awready, wready}), 256'(4'b0000));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_status", 256'(status), 256'(32'h10));

    run_phase(0);
    chk("key", aes_key, {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD,
                         32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD});
    chk("kg_start_pulses", 256'(kg_cnt), 256'(1));
    chk("kg_fin_before_done", 256'(status[2]), 256'(1'b0));
    @(negedge clk); aes_kg_done = 1'b1;
    @(negedge clk); aes_kg_done = 1'b0;
    chk("kg_fin_after_done", 256'(status[2]), 256'(1'b1));

    run_phase(1);
    chk("aes_din", 256'(aes_din), 256'(128'h000102030405060708090A0B0C0D0E0F));
    chk("enc_pulses_p1", 256'(enc_cnt), 256'(1));
    chk("dec_pulses_p1", 256'(dec_cnt), 256'(0));
    pulse_done(128'hdeae1a89b07f6e26246b3283cef7b78c);
    chk("status_after_enc_done", 256'(status), 256'(32'h2004));
    chk("control_after_done", 256'(control), 256'(32'd0));

    run_phase(2);
    run_phase(3);
    chk("dec_pulses_p3", 256'(dec_cnt), 256'(1));
    pulse_done(128'h11111111222222223333333344444444);
    chk("status_after_dec_done", 256'(status), 256'(32'h2004));

    run_phase(4);
    pulse_done(128'h55555555666666667777777788888888);
    chk("status_out_full", 256'(status), 256'(32'h4024));

    run_phase(5);
    // pop and result push land in the same cycle
    @(negedge clk);
    araddr = 6'h04; arlen = 8'd0; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("r_simul");
    chk("simul_rdata", 256'(rdata), 256'(32'h55555555));
    rready = 1'b1; aes_done = 1'b1;
    aes_dout = 128'h99999999ABCD0123456789ABFEDCBA98;
    @(posedge clk); #1 rready = 1'b0; aes_done = 1'b0;
    @(negedge clk);
    chk("simul_status", 256'(status), 256'(32'h3804));

    run_phase(6);
    chk("enc_pulses_total", 256'(enc_cnt), 256'(3));
    chk("dec_pulses_total", 256'(dec_cnt), 256'(1));

    axi_read(6'h00, 8'd1);
    chk("burst_rd_d0", 256'(rd_data[0]), 256'(32'h14));
    chk("burst_rd_d1", 256'(rd_data[1]), 256'(32'h14));
    chk("burst_rd_last", 256'({rd_last[0], rd_last[1]}), 256'(2'b01));

    axi_write(6'h04, 8'd2, 32'hABABABAB, 32'hCDCDCDCD, 32'hEFEFEFEF, resp, id);
    chk("burst_wr_bresp", 256'(resp), 256'(2'b00));
    chk("burst_wr_status", 256'(status), 256'(32'h314));

    // reset in the middle of a four-beat burst
    @(negedge clk);
    awaddr = 6'h04; awlen = 8'd3; awid = 1'b1; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk); wdata = 32'h01020304; wvalid = 1'b1;
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrst_bvalid", 256'(bvalid), 256'(1'b0));
    chk("midrst_status", 256'(status), 256'(32'd0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("after_midrst_status", 256'(status), 256'(32'h10));
    chk("after_midrst_idle", 256'({bvalid, wready}), 256'(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
